// File: rtl/kugelblitz_pkg.sv
// kugelblitz_pkg: rule record and index-width helpers shared by the byte-rewrite engine.
package kugelblitz_pkg;
  localparam int OFFSET_W_MAX = 32;
  localparam int MAX_RULES = 16;
  typedef struct packed {
    logic                    en;
    logic [OFFSET_W_MAX-1:0] offset;
    logic [7:0]              data;
  } rule_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int RULE_IDX_W = idx_w(MAX_RULES);
endpackage

// File: rtl/kugelblitz_rule_table.sv
// kugelblitz_rule_table: shadow/active rewrite rules; commits copy shadow to active only at frame boundaries.
module kugelblitz_rule_table
  import kugelblitz_pkg::*;
#(
  parameter int RULE_COUNT   = 4,
  parameter int OFFSET_WIDTH = 16
)(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [idx_w(RULE_COUNT)-1:0]      wr_rule,
  input  logic [OFFSET_WIDTH-1:0]           wr_offset,
  input  logic [7:0]                        wr_data,
  input  logic                              wr_rule_en,
  input  logic                              commit,
  input  logic                              tlast_hs,
  input  logic                              in_frame,
  input  logic                              beat_acc,
  output logic                              commit_pending,
  output logic [RULE_COUNT*$bits(rule_t)-1:0] active_flat
);
  localparam int RW = $bits(rule_t);
  rule_t shadow [RULE_COUNT];
  rule_t active [RULE_COUNT];
  logic copy;
  // copying between frames is only safe when no beat is starting a new frame this cycle
  assign copy = commit_pending && (tlast_hs || (!in_frame && !beat_acc));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
      for (int r = 0; r < RULE_COUNT; r++) begin
        shadow[r] <= '0;
        active[r] <= '0;
      end
    end else begin
      commit_pending <= commit || (commit_pending && !copy);
      for (int r = 0; r < RULE_COUNT; r++)
        if (copy) active[r] <= shadow[r];
      if (wr_en && int'(wr_rule) < RULE_COUNT)
        shadow[wr_rule] <= '{en: wr_rule_en, offset: OFFSET_W_MAX'(wr_offset), data: wr_data};
    end
  end
  for (genvar i = 0; i < RULE_COUNT; i++) begin : g_flat
    assign active_flat[i*RW +: RW] = active[i];
  end
endmodule

// File: rtl/kugelblitz_rewrite.sv
// kugelblitz_rewrite: registered AXI-Stream byte-rewrite engine with frame-aligned rule commits.
// Statistics counters are built only when KUGELBLITZ_REWRITE_STATS_EN is defined.
module kugelblitz_rewrite
  import kugelblitz_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 1,
  parameter int RULE_COUNT   = 4,
  parameter int OFFSET_WIDTH = 16,
  parameter int CNT_WIDTH    = 32
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          cfg_wr_en,
  input  logic [idx_w(RULE_COUNT)-1:0]  cfg_wr_rule,
  input  logic [OFFSET_WIDTH-1:0]       cfg_wr_offset,
  input  logic [7:0]                    cfg_wr_data,
  input  logic                          cfg_wr_rule_en,
  input  logic                          cfg_commit,
  output logic                          commit_pending,
  input  logic                          stat_clear,
  output logic [CNT_WIDTH-1:0]          stat_frames,
  output logic [CNT_WIDTH-1:0]          stat_rewrites
);
  localparam int RW = $bits(rule_t);
  localparam int BW = OFFSET_WIDTH + $clog2(KEEP_WIDTH) + 1;
  logic [RULE_COUNT*RW-1:0] active_flat;
  rule_t                    rules [RULE_COUNT];
  logic [OFFSET_WIDTH-1:0]  beat_cnt;
  logic                     in_frame;
  logic                     acc;
  logic                     last_hs;
  logic                     sat;
  logic [BW-1:0]            base;
  logic [KEEP_WIDTH-1:0]    hit;
  logic [DATA_WIDTH-1:0]    out_data;

  assign s_axis_tready = rst_n && (!m_axis_tvalid || m_axis_tready);
  assign acc = s_axis_tvalid && s_axis_tready;
  assign last_hs = acc && s_axis_tlast;
  assign sat = &beat_cnt;
  assign base = BW'(beat_cnt) * BW'(KEEP_WIDTH);

  kugelblitz_rule_table #(
    .RULE_COUNT   (RULE_COUNT),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_rules (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (cfg_wr_en),
    .wr_rule        (cfg_wr_rule),
    .wr_offset      (cfg_wr_offset),
    .wr_data        (cfg_wr_data),
    .wr_rule_en     (cfg_wr_rule_en),
    .commit         (cfg_commit),
    .tlast_hs       (last_hs),
    .in_frame       (in_frame),
    .beat_acc       (acc),
    .commit_pending (commit_pending),
    .active_flat    (active_flat)
  );

  for (genvar i = 0; i < RULE_COUNT; i++) begin : g_unpack
    assign rules[i] = active_flat[i*RW +: RW];
  end

  // descending scan so the lowest-indexed matching rule is the one left standing
  always_comb begin
    hit = '0;
    out_data = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      out_data[8*k +: 8] = s_axis_tkeep[k] ? s_axis_tdata[8*k +: 8] : 8'h00;
      for (int r = RULE_COUNT-1; r >= 0; r--)
        if (rules[r].en && s_axis_tkeep[k] && !sat &&
            64'(rules[r].offset) == 64'(base) + 64'(k)) begin
          hit[k] = 1'b1;
          out_data[8*k +: 8] = rules[r].data;
        end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else if (acc) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_data;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      in_frame <= 1'b0;
    end else if (last_hs) begin
      beat_cnt <= '0;
      in_frame <= 1'b0;
    end else if (acc) begin
      beat_cnt <= sat ? beat_cnt : beat_cnt + 1'b1;
      in_frame <= 1'b1;
    end
  end

`ifdef KUGELBLITZ_REWRITE_STATS_EN
  localparam int HW = $clog2(KEEP_WIDTH + 1);
  logic [HW-1:0] hit_cnt;
  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < KEEP_WIDTH; k++)
      hit_cnt = hit_cnt + HW'(hit[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames   <= '0;
      stat_rewrites <= '0;
    end else if (stat_clear) begin
      stat_frames   <= '0;
      stat_rewrites <= '0;
    end else begin
      if (last_hs) stat_frames <= stat_frames + 1'b1;
      if (acc) stat_rewrites <= stat_rewrites + CNT_WIDTH'(hit_cnt);
    end
  end
`else
  logic unused_stat;
  assign unused_stat = stat_clear | (|hit);
  assign stat_frames = '0;
  assign stat_rewrites = '0;
`endif
endmodule

// File: tb/tb_kugelblitz_rewrite.sv
// tb_kugelblitz_rewrite: directed vectors plus a randomized-backpressure run against a byte-level reference model.
module tb_kugelblitz_rewrite;
  localparam int DW = 512;
  localparam int KW = 64;
`ifdef KUGELBLITZ_REWRITE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [0:0]    s_axis_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic          cfg_wr_en = 1'b0;
  logic [1:0]    cfg_wr_rule = '0;
  logic [15:0]   cfg_wr_offset = '0;
  logic [7:0]    cfg_wr_data = '0;
  logic          cfg_wr_rule_en = 1'b0;
  logic          cfg_commit = 1'b0;
  logic          commit_pending;
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_frames;
  logic [31:0]   stat_rewrites;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    rnd_en = 1'b0;
  beat_t out_q[$];
  beat_t exp_q[$];
  int    mo[4];
  logic [7:0] md[4];

  always #5 clk = ~clk;

  kugelblitz_rewrite dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_rule(cfg_wr_rule), .cfg_wr_offset(cfg_wr_offset),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_rule_en(cfg_wr_rule_en), .cfg_commit(cfg_commit),
    .commit_pending(commit_pending), .stat_clear(stat_clear),
    .stat_frames(stat_frames), .stat_rewrites(stat_rewrites)
  );

  always @(negedge clk) m_axis_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(negedge clk) begin
    #4;
    if (rst_n && m_axis_tvalid && m_axis_tready)
      out_q.push_back(beat_t'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}));
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [7:0] s);
    logic [DW-1:0] v;
    for (int k = 0; k < KW; k++) v[8*k +: 8] = s + 8'(k);
    return v;
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                                          input int bi, output int hits);
    logic [DW-1:0] v;
    hits = 0;
    for (int k = 0; k < KW; k++) begin
      v[8*k +: 8] = kp[k] ? d[8*k +: 8] : 8'h00;
      if (kp[k])
        for (int r = 0; r < 4; r++)
          if (mo[r] == bi*KW + k) begin
            v[8*k +: 8] = md[r];
            hits++;
            break;
          end
    end
    return v;
  endfunction

  task automatic wr_rule(input int r, input int off, input logic [7:0] d, input logic en);
    cfg_wr_en = 1'b1; cfg_wr_rule = 2'(r); cfg_wr_offset = 16'(off);
    cfg_wr_data = d; cfg_wr_rule_en = en;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] kp, input logic l);
    bit ok = 1'b0;
    int n = 0;
    s_axis_tdata = d; s_axis_tkeep = kp; s_axis_tlast = l;
    s_axis_tuser = d[0]; s_axis_tvalid = 1'b1;
    while (!ok && n < 200) begin
      #4 ok = s_axis_tready;
      @(negedge clk);
      n++;
    end
    s_axis_tvalid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic get_out(output beat_t b);
    int n = 0;
    while (out_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (out_q.size() == 0) begin
      check("out_timeout", 0, 1);
      b = '0;
    end else b = out_q.pop_front();
  endtask

  initial begin
    beat_t b;
    logic [DW-1:0] d, d2, e;
    logic [KW-1:0] kp;
    int hits, tot_hits, len, n;
    #1 rst_n = 1'b0;
    #1;
    check("rst_tready", s_axis_tready, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_mdata", m_axis_tdata, 0);
    check("rst_pend", commit_pending, 0);
    check("rst_frames", stat_frames, 0);
    check("rst_rewrites", stat_rewrites, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tready", s_axis_tready, 1);

    wr_rule(0, 3, 8'hAA, 1'b1);
    commit();
    check("t1_pend_set", commit_pending, 1);
    @(negedge clk);
    check("t1_pend_clr", commit_pending, 0);
    d = pat(8'h00);
    send(d, '1, 1'b1);
    get_out(b);
    e = d; e[31:24] = 8'hAA;
    check("t1_data", b.d, e);
    check("t1_keep_last", {b.k, b.l}, {{KW{1'b1}}, 1'b1});
    check("t1_frames", stat_frames, STATS ? 1 : 0);
    check("t1_rewrites", stat_rewrites, STATS ? 1 : 0);

    wr_rule(0, 3, 8'hAA, 1'b0);
    wr_rule(1, 70, 8'h55, 1'b1);
    commit(); @(negedge clk);
    d = pat(8'h40); d2 = pat(8'h80);
    send(d, '1, 1'b0);
    send(d2, '1, 1'b1);
    get_out(b);
    check("t2_beat0", b.d, d);
    check("t2_last0", b.l, 0);
    get_out(b);
    e = d2; e[55:48] = 8'h55;
    check("t2_beat1", b.d, e);
    check("t2_last1", b.l, 1);

    wr_rule(1, 70, 8'h55, 1'b0);
    wr_rule(2, 10, 8'h22, 1'b1);
    wr_rule(0, 10, 8'h11, 1'b1);
    commit(); @(negedge clk);
    d = pat(8'h20);
    send(d, '1, 1'b1);
    get_out(b);
    e = d; e[87:80] = 8'h11;
    check("t3_prio", b.d, e);

    wr_rule(2, 10, 8'h22, 1'b0);
    wr_rule(0, 5, 8'h77, 1'b1);
    commit(); @(negedge clk);
    d = pat(8'hC0);
    send(d, 64'h0F, 1'b1);
    get_out(b);
    e = '0; e[31:0] = d[31:0];
    check("t4_data", b.d, e);
    check("t4_keep", b.k, 64'h0F);
    check("t4_frames", stat_frames, STATS ? 4 : 0);
    check("t4_rewrites", stat_rewrites, STATS ? 3 : 0);

    stat_clear = 1'b1;
    d = pat(8'h01);
    send(d, '1, 1'b1);
    stat_clear = 1'b0;
    check("clr_frames", stat_frames, 0);
    check("clr_rewrites", stat_rewrites, 0);
    get_out(b);
    e = d; e[47:40] = 8'h77;
    check("clr_data", b.d, e);

    wr_rule(0, 69, 8'h77, 1'b1);
    wr_rule(1, 133, 8'h78, 1'b1);
    commit(); @(negedge clk);
    send(pat(8'h00), '1, 1'b0);
    wr_rule(0, 69, 8'h99, 1'b1);
    commit();
    check("t5_pend_mid", commit_pending, 1);
    send(pat(8'h10), '1, 1'b0);
    send(pat(8'h20), '1, 1'b0);
    check("t5_pend_hold", commit_pending, 1);
    send(pat(8'h30), '1, 1'b1);
    check("t5_pend_fall", commit_pending, 0);
    get_out(b); check("t5_b0", b.d, pat(8'h00));
    get_out(b); e = pat(8'h10); e[47:40] = 8'h77; check("t5_b1_old", b.d, e);
    get_out(b); e = pat(8'h20); e[47:40] = 8'h78; check("t5_b2", b.d, e);
    get_out(b); check("t5_b3", b.d, pat(8'h30));
    send(pat(8'h50), '1, 1'b0);
    send(pat(8'h60), '1, 1'b1);
    get_out(b); check("t5_n0", b.d, pat(8'h50));
    get_out(b); e = pat(8'h60); e[47:40] = 8'h99; check("t5_n1_new", b.d, e);

    mo = '{3, 70, 130, 3};
    md = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int r = 0; r < 4; r++) wr_rule(r, mo[r], md[r], 1'b1);
    commit(); @(negedge clk);
    stat_clear = 1'b1; @(negedge clk); stat_clear = 1'b0;
    out_q.delete();
    tot_hits = 0;
    rnd_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 4);
      for (int bi = 0; bi < len; bi++) begin
        for (int w = 0; w < DW/32; w++) d[32*w +: 32] = $urandom();
        kp = (bi == len-1) ? {$urandom(), $urandom()} : '1;
        e = model(d, kp, bi, hits);
        tot_hits += hits;
        exp_q.push_back(beat_t'({e, kp, bi == len-1, d[0]}));
        send(d, kp, bi == len-1);
      end
    end
    n = 0;
    while (out_q.size() < exp_q.size() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    rnd_en = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rnd_count", out_q.size(), exp_q.size());
    while (exp_q.size() > 0 && out_q.size() > 0) begin
      beat_t x;
      x = exp_q.pop_front();
      b = out_q.pop_front();
      check("rnd_data", b.d, x.d);
      check("rnd_ctl", {b.k, b.l, b.u}, {x.k, x.l, x.u});
    end
    check("rnd_frames", stat_frames, STATS ? 100 : 0);
    check("rnd_rewrites", stat_rewrites, STATS ? tot_hits : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
